// File: rtl/crossbar_seq_if.sv
// Command/response bundle between user-project logic and the crossbar sequencer.
// The master modport is the requester side. The slave modport is the sequencer side.
interface crossbar_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_row;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_row, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_row, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/crossbar_seq.sv
// Command sequencer for the 8x8 ReRAM crossbar MAC array.
// It turns CLEAR/WRITE/MAC/FORM commands into timed wordline/bitline/selectline pulses.
// It samples the thresholded column outputs at the end of a MAC read window and returns them.
// Optional macro XBAR_PERF_CNT_EN adds two saturating activity counters: wr_count and mac_count.
module crossbar_seq #(
  parameter int PULSE_CYCLES = 2,   // SET/RESET pulse width, 1..15
  parameter int FORM_CYCLES  = 8,   // FORM pulse width, 1..255
  parameter int READ_CYCLES  = 2    // MAC window before sampling, 2..15
) (
  input  logic        clk,
  input  logic        rst_n,
  crossbar_seq_if.slave bus,
  output logic        busy,
  output logic [7:0]  xb_bitline,
  output logic [7:0]  xb_wordline,
  output logic [7:0]  xb_selectline,
  output logic        xb_wenable,
  output logic        xb_form,
  output logic        xb_mac,
  input  logic [7:0]  xb_out
`ifdef XBAR_PERF_CNT_EN
  ,
  output logic [15:0] wr_count,
  output logic [15:0] mac_count
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PULSE = 3'd1,
    ST_GAP   = 3'd2,
    ST_READ  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_MAC   = 2'b10;
  localparam logic [1:0] OP_FORM  = 2'b11;

  // Counters count down to zero, so each load value is the pulse width minus one.
  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] FORM_LOAD  = 8'(FORM_CYCLES - 1);
  localparam logic [7:0] READ_LOAD  = 8'(READ_CYCLES - 1);

  state_t     state_q;
  logic [1:0] op_q;
  logic [2:0] clr_row_q;
  logic [7:0] cnt_q;
  logic       cmd_ready_q;
  logic       busy_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_data_q;
  logic [7:0] wl_q;
  logic [7:0] bl_q;
  logic [7:0] sl_q;
  logic       we_q;
  logic       form_q;
  logic       mac_q;

  function automatic logic [7:0] onehot(input logic [2:0] row);
    return 8'h01 << row;
  endfunction

  // Sequencer FSM. Every crossbar line and every handshake output is a register here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_CLEAR;
      clr_row_q   <= 3'd0;
      cnt_q       <= 8'd0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'd0;
      wl_q        <= 8'd0;
      bl_q        <= 8'd0;
      sl_q        <= 8'd0;
      we_q        <= 1'b0;
      form_q      <= 1'b0;
      mac_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            op_q        <= bus.cmd_op;
            clr_row_q   <= 3'd0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            case (bus.cmd_op)
              OP_MAC: begin
                state_q <= ST_READ;
                cnt_q   <= READ_LOAD;
                wl_q    <= bus.cmd_data;
                bl_q    <= 8'h00;
                sl_q    <= 8'h00;
                mac_q   <= 1'b1;
              end
              OP_WRITE: begin
                // A 1 bit SETs its cell and a 0 bit RESETs its cell, both in the same pulse.
                state_q <= ST_PULSE;
                cnt_q   <= PULSE_LOAD;
                wl_q    <= onehot(bus.cmd_row);
                bl_q    <= bus.cmd_data;
                sl_q    <= ~bus.cmd_data;
                we_q    <= 1'b1;
              end
              OP_FORM: begin
                state_q <= ST_PULSE;
                cnt_q   <= FORM_LOAD;
                wl_q    <= onehot(bus.cmd_row);
                bl_q    <= 8'hFF;
                sl_q    <= 8'h00;
                form_q  <= 1'b1;
              end
              default: begin
                // CLEAR starts at row 0. GAP walks the following rows.
                state_q <= ST_PULSE;
                cnt_q   <= PULSE_LOAD;
                wl_q    <= onehot(3'd0);
                bl_q    <= 8'h00;
                sl_q    <= 8'hFF;
                we_q    <= 1'b1;
              end
            endcase
          end else begin
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end

        ST_PULSE: begin
          if (cnt_q == 8'd0) begin
            state_q <= ST_GAP;
            wl_q    <= 8'h00;
            bl_q    <= 8'h00;
            sl_q    <= 8'h00;
            we_q    <= 1'b0;
            form_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end

        ST_GAP: begin
          if ((op_q == OP_CLEAR) && (clr_row_q != 3'd7)) begin
            clr_row_q <= clr_row_q + 3'd1;
            state_q   <= ST_PULSE;
            cnt_q     <= PULSE_LOAD;
            wl_q      <= onehot(clr_row_q + 3'd1);
            bl_q      <= 8'h00;
            sl_q      <= 8'hFF;
            we_q      <= 1'b1;
          end else begin
            clr_row_q   <= 3'd0;
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end

        ST_READ: begin
          if (cnt_q == 8'd0) begin
            // Sample on the final READ edge, while the wordlines are still driven.
            rsp_data_q  <= xb_out;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
            wl_q        <= 8'h00;
            mac_q       <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end

        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
          end else begin
            rsp_valid_q <= 1'b1;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b0;
          busy_q      <= 1'b0;
          rsp_valid_q <= 1'b0;
          wl_q        <= 8'h00;
          bl_q        <= 8'h00;
          sl_q        <= 8'h00;
          we_q        <= 1'b0;
          form_q      <= 1'b0;
          mac_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign busy          = busy_q;
  assign xb_wordline   = wl_q;
  assign xb_bitline    = bl_q;
  assign xb_selectline = sl_q;
  assign xb_wenable    = we_q;
  assign xb_form       = form_q;
  assign xb_mac        = mac_q;

`ifdef XBAR_PERF_CNT_EN
  logic [15:0] wr_count_q, wr_count_d;
  logic [15:0] mac_count_q, mac_count_d;
  logic        wr_accept_s;
  logic        rsp_done_s;

  assign wr_accept_s = (state_q == ST_IDLE) && bus.cmd_valid && cmd_ready_q && (bus.cmd_op != OP_MAC);
  assign rsp_done_s  = (state_q == ST_RESP) && rsp_valid_q && bus.rsp_ready;

  // Saturating next values for the activity counters.
  always_comb begin
    wr_count_d  = wr_count_q;
    mac_count_d = mac_count_q;
    if (wr_accept_s && (wr_count_q != 16'hFFFF)) begin
      wr_count_d = wr_count_q + 16'd1;
    end else begin
      wr_count_d = wr_count_q;
    end
    if (rsp_done_s && (mac_count_q != 16'hFFFF)) begin
      mac_count_d = mac_count_q + 16'd1;
    end else begin
      mac_count_d = mac_count_q;
    end
  end

  // Activity counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count_q  <= 16'd0;
      mac_count_q <= 16'd0;
    end else begin
      wr_count_q  <= wr_count_d;
      mac_count_q <= mac_count_d;
    end
  end

  assign wr_count  = wr_count_q;
  assign mac_count = mac_count_q;
`endif

endmodule
